// File: rtl/trb_ctrl.sv
// trb_ctrl: sequences sample blocks into transpose_buffer and tags its transposed output
// with block position and component, handling priming, padding and end-of-stream drain.
module trb_ctrl #(
    parameter int W = 12,
    parameter int N = 8,
    parameter int NCOMP = 3,
    localparam int BEATS = N * N,
    localparam int PW = $clog2(BEATS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          trb_ena,
    output logic [W-1:0]  trb_in,
    input  logic [W-1:0]  trb_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [PW-1:0] out_pos,
    output logic [1:0]    out_comp,
    output logic          out_last
);
    typedef enum logic [2:0] {IDLE, FILL, STREAM, PAD, DRAIN} state_t;
    state_t state_q, state_d;
    logic [PW:0] fill_q, fill_d;
    logic [PW-1:0] in_pos_q, in_pos_d, out_pos_q, out_pos_d, drain_q, drain_d;
    logic [1:0] comp_q, comp_d;
    logic primed, accept, xfer, pos_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            fill_q   <= '0;
            in_pos_q <= '0;
            out_pos_q <= '0;
            drain_q  <= '0;
            comp_q   <= '0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            in_pos_q <= in_pos_d;
            out_pos_q <= out_pos_d;
            drain_q  <= drain_d;
            comp_q   <= comp_d;
        end
    end

    always_comb begin
        primed = fill_q == (PW+1)'(BEATS);
        pos_end = in_pos_q == PW'(BEATS - 1);
        in_ready = 1'b0;
        out_valid = 1'b0;
        trb_ena = 1'b0;
        case (state_q)
            IDLE, FILL: begin
                in_ready = 1'b1;
                trb_ena = in_valid;
            end
            STREAM: begin
                in_ready = out_ready;
                out_valid = in_valid;
                trb_ena = in_valid && out_ready;
            end
            PAD: begin
                out_valid = primed;
                trb_ena = !primed || out_ready;
            end
            DRAIN: begin
                out_valid = 1'b1;
                trb_ena = out_ready;
            end
            default: ;
        endcase
        // no beat may reach the buffer while it is being cleared
        trb_ena = trb_ena && !rst;
        accept = trb_ena && in_ready;
        xfer = out_valid && out_ready && !rst;
        trb_in = accept ? in_data : '0;
        out_data = trb_out;
        out_pos = out_pos_q;
        out_comp = comp_q;
        out_last = state_q == DRAIN && drain_q == PW'(BEATS - 1);
        state_d = state_q;
        fill_d = fill_q;
        in_pos_d = in_pos_q;
        out_pos_d = out_pos_q;
        drain_d = drain_q;
        comp_d = comp_q;
        if (trb_ena && state_q != DRAIN) begin
            in_pos_d = pos_end ? '0 : in_pos_q + 1'b1;
            fill_d = primed ? fill_q : fill_q + 1'b1;
        end
        if (xfer) begin
            out_pos_d = out_pos_q == PW'(BEATS - 1) ? '0 : out_pos_q + 1'b1;
            if (out_pos_q == PW'(BEATS - 1))
                comp_d = comp_q == 2'(NCOMP - 1) ? 2'd0 : comp_q + 1'b1;
        end
        if (accept && in_last)
            state_d = pos_end ? DRAIN : PAD;
        else if (accept && (state_q == IDLE || state_q == FILL))
            state_d = fill_d == (PW+1)'(BEATS) ? STREAM : FILL;
        else if (state_q == PAD && trb_ena && pos_end)
            state_d = DRAIN;
        if (state_q == DRAIN && trb_ena) begin
            drain_d = drain_q + 1'b1;
            if (drain_q == PW'(BEATS - 1)) begin
                state_d = IDLE;
                fill_d = '0;
                in_pos_d = '0;
                out_pos_d = '0;
                drain_d = '0;
                comp_d = '0;
            end
        end
    end
endmodule

// File: tb/tb_trb_ctrl.sv
// tb_trb_ctrl: directed streams through trb_ctrl with a transposing-buffer model and a
// scoreboard that predicts every output word from the stimulus padded to whole blocks.
module tb_trb_ctrl;
    localparam int W = 12, N = 8, NCOMP = 3, BEATS = 64;
    logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
    logic [W-1:0] in_data = '0;
    logic in_ready, trb_ena, out_valid, out_last;
    logic [W-1:0] trb_in, trb_out, out_data;
    logic [5:0] out_pos;
    logic [1:0] out_comp;
    int tests = 0, fails = 0;
    logic [W-1:0] hist [0:4095];
    int m = 0;
    int stim [0:255];
    int stim_n = 0, p_len = 0;
    int acc_cnt = 0, out_idx = 0, ena_cnt = 0, zb = 0, zb_pre = 0, cyc = 0, c64 = -1, c_ov = -1, out_total = 0;
    bit last_seen = 0, done = 0, bp = 0;
    int got [0:255];

    trb_ctrl #(.W(W), .N(N), .NCOMP(NCOMP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .trb_ena(trb_ena), .trb_in(trb_in), .trb_out(trb_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pos(out_pos), .out_comp(out_comp), .out_last(out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) m <= 0;
        else if (trb_ena) begin
            hist[m % 4096] <= trb_in;
            m <= m + 1;
        end
    end

    // buffer head: block-wise transpose of the shifted-in words, BEATS enabled beats behind
    always_comb begin
        int j, s;
        j = (m >= BEATS) ? m - BEATS : 0;
        s = (j / BEATS) * BEATS + (j % N) * N + (j % BEATS) / N;
        trb_out = (m >= BEATS) ? hist[s % 4096] : '0;
    end

    always @(posedge clk) begin
        #1;
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int j, k, s, ex;
        bit acc;
        cyc++;
        if (rst) begin
            acc_cnt = 0;
            out_idx = 0;
            last_seen = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_trb_ena", trb_ena, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_pos", out_pos, 0);
            chk("rst_out_comp", out_comp, 0);
            chk("rst_out_last", out_last, 0);
        end else begin
            acc = in_valid && in_ready;
            if (!last_seen && acc_cnt < BEATS) begin
                chk("fill_in_ready", in_ready, 1);
                chk("fill_out_valid", out_valid, 0);
                chk("fill_ena", trb_ena, in_valid);
            end else if (!last_seen) begin
                chk("stream_in_ready", in_ready, out_ready);
                chk("stream_out_valid", out_valid, in_valid);
                chk("stream_ena", trb_ena, in_valid && out_ready);
            end else chk("tail_in_ready", in_ready, 0);
            if (trb_ena) begin
                ena_cnt++;
                chk("trb_in", trb_in, acc ? in_data : 0);
                if (!acc) begin
                    zb++;
                    if (!out_valid) zb_pre++;
                end
            end
            if (out_valid && c_ov < 0) c_ov = cyc;
            if (acc) begin
                acc_cnt++;
                if (acc_cnt == BEATS) c64 = cyc;
                if (in_last) last_seen = 1;
            end
            if (out_valid && out_ready) begin
                j = out_idx;
                k = j % BEATS;
                s = (j / BEATS) * BEATS + (k % N) * N + k / N;
                ex = s < stim_n ? stim[s] : 0;
                chk("out_data", out_data, ex);
                chk("out_pos", out_pos, k);
                chk("out_comp", out_comp, (j / BEATS) % NCOMP);
                chk("out_last", out_last, j == p_len - 1);
                got[j % 256] = out_data;
                out_idx++;
                if (out_last) begin
                    done = 1;
                    out_total = out_idx;
                    out_idx = 0;
                    acc_cnt = 0;
                    last_seen = 0;
                end
            end
        end
    end

    task automatic run(input int n, input int base, input bit gap, input int stop_at);
        int i = 0;
        bit ph = 0, acc;
        stim_n = n;
        p_len = ((n + BEATS - 1) / BEATS) * BEATS;
        for (int k = 0; k < n; k++) stim[k] = (base + k) % 4096;
        ena_cnt = 0; zb = 0; zb_pre = 0; c_ov = -1; c64 = -1; done = 0; out_total = 0;
        while (i < n && i < stop_at) begin
            in_valid = !(gap && ph);
            in_data = W'(stim[i]);
            in_last = (i == n - 1);
            ph = !ph;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
        end
        in_valid = 0;
        in_last = 0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!done && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, done, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        run(192, 1, 0, 1000);
        wait_done("full_done");
        chk("full_ena_cnt", ena_cnt, 256);
        chk("full_first_valid", c_ov - c64, 1);
        chk("full_outs", out_total, 192);
        chk("full_zero_beats", zb, 64);
        chk("full_w1", got[1], 9);
        chk("full_w8", got[8], 2);
        chk("full_w63", got[63], 64);
        chk("full_w64", got[64], 65);
        bp = 1;
        run(192, 1, 0, 1000);
        wait_done("bp_done");
        bp = 0;
        chk("bp_ena_cnt", ena_cnt, 256);
        chk("bp_outs", out_total, 192);
        repeat (2) @(posedge clk);
        #1;
        run(64, 100, 1, 1000);
        wait_done("gap_done");
        chk("gap_ena_cnt", ena_cnt, 128);
        chk("gap_first_valid", c_ov - c64, 1);
        chk("gap_outs", out_total, 64);
        chk("gap_pad", zb_pre, 0);
        chk("gap_w1", got[1], 108);
        run(10, 1, 0, 1000);
        wait_done("part_done");
        chk("part_ena_cnt", ena_cnt, 128);
        chk("part_zero_beats", zb, 118);
        chk("part_pad_beats", zb_pre, 54);
        chk("part_outs", out_total, 64);
        chk("part_w0", got[0], 1);
        chk("part_w1", got[1], 9);
        chk("part_w2", got[2], 0);
        chk("part_w8", got[8], 2);
        chk("part_w9", got[9], 10);
        run(192, 1, 0, 100);
        rst = 1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_trb_ena", trb_ena, 0);
        chk("mid_rst_out_pos", out_pos, 0);
        chk("mid_rst_out_comp", out_comp, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        run(64, 1, 0, 1000);
        wait_done("fresh_done");
        chk("fresh_outs", out_total, 64);
        chk("fresh_ena_cnt", ena_cnt, 128);
        chk("fresh_w1", got[1], 9);
        chk("fresh_w63", got[63], 64);
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
